// File: rtl/i2s_master_pkg.sv
// Shared types for the I2S master.
// Channel encoding matches the WS line level.
package i2s_master_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  function automatic ch_e ch_of(input logic i_right);
    return i_right ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: free-running div_cnt, registered SCK,
// and single-clk rise/fall strobes decoded from the count.
module i2s_sck_gen
  import i2s_master_pkg::*;
#(
  parameter int CLK_DIV = 256
) (
  input  logic i_clk,
  input  logic i_arstn,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic          r_sck;

  assign o_rise = (r_div_cnt == RISE_AT);
  assign o_fall = (r_div_cnt == FALL_AT);
  assign o_sck  = r_sck;

  // divider counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_div_cnt <= '0;
    end else if (o_fall) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // sck toggles on the two decoded strobes
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_sck <= 1'b0;
    end else if (o_rise) begin
      r_sck <= 1'b1;
    end else if (o_fall) begin
      r_sck <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_master.sv
// Stereo Philips I2S master: slot/WS sequencing,
// MSB-first TX on SCK falls, RX sampling on SCK rises.
module i2s_master
  import i2s_master_pkg::*;
#(
  parameter int CLK_DIV    = 256,
  parameter int WS_DIV     = 64,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  arstn,
  output logic                  sck,
  output logic                  ws,
  input  logic                  sdi,
  output logic                  sdo,
  input  logic [DATA_WIDTH-1:0] data_send_left,
  input  logic [DATA_WIDTH-1:0] data_send_right,
  output logic [DATA_WIDTH-1:0] data_recv_left,
  output logic [DATA_WIDTH-1:0] data_recv_right
);

  localparam int H  = WS_DIV / 2;
  localparam int SW = $clog2(WS_DIV);
  localparam int DW = DATA_WIDTH;

  localparam logic [SW-1:0] SLOT_LAST = SW'(WS_DIV - 1);
  localparam logic [SW-1:0] HALF      = SW'(H);
  localparam logic [SW-1:0] J_ONE     = SW'(1);
  localparam logic [SW-1:0] J_TWO     = SW'(2);
  localparam logic [SW-1:0] J_LAST    = SW'(DW);

  function automatic logic [SW-1:0] slot_j(
    input logic [SW-1:0] i_s
  );
    return (i_s >= HALF) ? i_s - HALF : i_s;
  endfunction

  logic          w_sck;
  logic          w_rise;
  logic          w_fall;

  logic [SW-1:0] r_slot;
  ch_e           r_ch;
  logic          r_sdo;
  logic [DW-1:0] r_tx_shift;
  logic [DW-1:0] r_rx_shift;
  logic [DW-1:0] r_recv_l;
  logic [DW-1:0] r_recv_r;

  logic [SW-1:0] w_slot_nxt;
  logic [SW-1:0] w_j;
  logic [SW-1:0] w_j_nxt;
  ch_e           w_ch_nxt;
  logic [DW-1:0] w_tx_word;
  logic [DW-1:0] w_tx_next;
  logic [DW-1:0] w_rx_next;
  logic          w_rx_bit;
  logic          w_rx_done;

  i2s_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .i_clk  (clk),
    .i_arstn(arstn),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_slot_nxt = (r_slot == SLOT_LAST)
                    ? '0 : r_slot + 1'b1;
  assign w_j        = slot_j(r_slot);
  assign w_j_nxt    = slot_j(w_slot_nxt);
  assign w_ch_nxt   = ch_of(w_slot_nxt >= HALF);
  assign w_tx_word  = (w_ch_nxt == CH_RIGHT)
                    ? data_send_right
                    : data_send_left;
  assign w_tx_next  = r_tx_shift << 1;
  assign w_rx_next  = (r_rx_shift << 1) | DW'(sdi);
  assign w_rx_bit   = w_rise
                    && (w_j >= J_ONE)
                    && (w_j <= J_LAST);
  assign w_rx_done  = w_rise && (w_j == J_LAST);

  assign sck             = w_sck;
  assign ws              = (r_ch == CH_RIGHT);
  assign sdo             = r_sdo;
  assign data_recv_left  = r_recv_l;
  assign data_recv_right = r_recv_r;

  // slot and ws advance on the SCK fall, one bit ahead of the MSB
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_slot <= '0;
      r_ch   <= CH_LEFT;
    end else if (w_fall) begin
      r_slot <= w_slot_nxt;
      r_ch   <= w_ch_nxt;
    end
  end

  // word is latched entering j==1, then shifted out MSB first
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_tx_shift <= '0;
      r_sdo      <= 1'b0;
    end else if (w_fall) begin
      unique case (1'b1)
        (w_j_nxt == J_ONE): begin
          r_tx_shift <= w_tx_word;
          r_sdo      <= w_tx_word[DW-1];
        end
        ((w_j_nxt >= J_TWO) && (w_j_nxt <= J_LAST)): begin
          r_tx_shift <= w_tx_next;
          r_sdo      <= w_tx_next[DW-1];
        end
        default: begin
          r_sdo <= 1'b0;
        end
      endcase
    end
  end

  // sdi is shifted in on rises within the data slots
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_rx_shift <= '0;
    end else if (w_rx_bit) begin
      r_rx_shift <= w_rx_next;
    end
  end

  // completed word lands in the channel selected by ws
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_recv_l <= '0;
      r_recv_r <= '0;
    end else if (w_rx_done) begin
      if (r_ch == CH_RIGHT) begin
        r_recv_r <= w_rx_next;
      end else begin
        r_recv_l <= w_rx_next;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master.sv
// Bench for i2s_master: cycle-indexed behavioural model,
// per-cycle compare, plus literal timing and word checks.
module tb_i2s_master;

  localparam int C  = 8;
  localparam int WS = 64;
  localparam int H  = WS / 2;
  localparam int DW = 24;
  localparam int FR = C * WS;

  logic clk;
  logic arstn;

  logic          sck_a, ws_a, sdo_a, sdi_a;
  logic [DW-1:0] send_l, send_r;
  logic [DW-1:0] recv_l, recv_r;
  logic          loop_a;
  logic          rnd;

  logic          sck_b, ws_b, sdo_b;
  logic [30:0]   send_lb, send_rb;
  logic [30:0]   recv_lb, recv_rb;

  logic          sck_d, ws_d, sdo_d;
  logic [23:0]   send_ld, send_rd;
  logic [23:0]   recv_ld, recv_rd;

  int checks = 0;
  int errors = 0;
  int m_n    = 0;
  logic meas_done = 1'b0;

  logic [DW-1:0] cap [2];
  logic [DW-1:0] exp_recv [2];
  logic [DW:1]   bits [2];

  assign sdi_a = loop_a ? sdo_a : rnd;

  i2s_master #(
    .CLK_DIV(C), .WS_DIV(WS), .DATA_WIDTH(DW)
  ) u_a (
    .clk(clk), .arstn(arstn),
    .sck(sck_a), .ws(ws_a),
    .sdi(sdi_a), .sdo(sdo_a),
    .data_send_left(send_l),
    .data_send_right(send_r),
    .data_recv_left(recv_l),
    .data_recv_right(recv_r)
  );

  i2s_master #(
    .CLK_DIV(C), .WS_DIV(WS), .DATA_WIDTH(31)
  ) u_b (
    .clk(clk), .arstn(arstn),
    .sck(sck_b), .ws(ws_b),
    .sdi(sdo_b), .sdo(sdo_b),
    .data_send_left(send_lb),
    .data_send_right(send_rb),
    .data_recv_left(recv_lb),
    .data_recv_right(recv_rb)
  );

  i2s_master u_d (
    .clk(clk), .arstn(arstn),
    .sck(sck_d), .ws(ws_d),
    .sdi(sdo_d), .sdo(sdo_d),
    .data_send_left(send_ld),
    .data_send_right(send_rd),
    .data_recv_left(recv_ld),
    .data_recv_right(recv_rd)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  function automatic int cur_slot();
    return (m_n / C) % WS;
  endfunction

  task automatic wait_slot(input int tgt);
    int k;
    k = 0;
    while (cur_slot() != tgt && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    if (cur_slot() != tgt) begin
      chk("wait_slot", 32'(cur_slot()), 32'(tgt));
    end
  endtask

  // random sdi changes only after SCK falls
  initial begin
    rnd = 1'b0;
    forever begin
      @(negedge sck_a);
      rnd = 1'($urandom_range(0, 1));
    end
  end

  // model: edge index since reset gives slot/bit position
  always @(posedge clk or negedge arstn) begin : model
    int s, h, j;
    logic [DW-1:0] w;
    if (!arstn) begin
      m_n = 0;
      for (int c = 0; c < 2; c++) begin
        cap[c] = '0;
        exp_recv[c] = '0;
        bits[c] = '0;
      end
    end else begin
      m_n = m_n + 1;
      s = (m_n / C) % WS;
      h = s / H;
      j = s % H;
      if (m_n % C == 0 && j == 1)
        cap[h] = (h == 1) ? send_r : send_l;
      if (m_n % C == C / 2 && j >= 1 && j <= DW) begin
        bits[h][j] = sdi_a;
        if (j == DW) begin
          w = '0;
          for (int k = 1; k <= DW; k++)
            w[DW-k] = bits[h][k];
          exp_recv[h] = w;
        end
      end
    end
  end

  // per-cycle comparison of u_a against the model
  always @(negedge clk) begin : cmp
    int s, h, j;
    logic e_sdo;
    s = (m_n / C) % WS;
    h = s / H;
    j = s % H;
    e_sdo = (j >= 1 && j <= DW) ? cap[h][DW-j] : 1'b0;
    chk("sck", 32'(sck_a), 32'((m_n % C) >= C / 2));
    chk("ws", 32'(ws_a), 32'(h));
    chk("sdo", 32'(sdo_a), 32'(e_sdo));
    chk("recv_l", 32'(recv_l), 32'(exp_recv[0]));
    chk("recv_r", 32'(recv_r), 32'(exp_recv[1]));
  end

  // default-parameter timing: SCK and WS edges in clks
  initial begin : meas
    int r1, r2, wr, wf;
    logic ps, pw;
    r1 = -1; r2 = -1; wr = -1; wf = -1;
    ps = 1'b0; pw = 1'b0;
    wait (arstn === 1'b1);
    for (int i = 0; i < 20000 && wf < 0; i++) begin
      @(negedge clk);
      if (sck_d && !ps) begin
        if (r1 < 0) r1 = m_n;
        else if (r2 < 0) r2 = m_n;
      end
      if (ws_d && !pw && wr < 0) wr = m_n;
      if (!ws_d && pw && wf < 0) wf = m_n;
      ps = sck_d;
      pw = ws_d;
    end
    chk("def_first_rise", 32'(r1), 32'd128);
    chk("def_sck_period", 32'(r2 - r1), 32'd256);
    chk("def_ws_rise", 32'(wr), 32'd8192);
    chk("def_ws_high", 32'(wf - wr), 32'd8192);
    meas_done = 1'b1;
  end

  initial begin : main
    int k;
    arstn   = 1'b0;
    loop_a  = 1'b1;
    send_l  = 24'h123456;
    send_r  = 24'habcdef;
    send_lb = 31'h1234_5678;
    send_rb = 31'h5bcd_ef01;
    send_ld = 24'h123456;
    send_rd = 24'habcdef;
    repeat (5) @(negedge clk);
    chk("rst_sck_d", 32'(sck_d), 32'd0);
    chk("rst_ws_d", 32'(ws_d), 32'd0);
    chk("rst_sdo_d", 32'(sdo_d), 32'd0);
    chk("rst_recv_lb", 32'(recv_lb), 32'd0);
    arstn = 1'b1;

    repeat (2 * FR + 16) @(negedge clk);
    chk("loop_l", 32'(recv_l), 32'h123456);
    chk("loop_r", 32'(recv_r), 32'habcdef);
    chk("dw31_l", 32'(recv_lb), 32'h1234_5678);
    chk("dw31_r", 32'(recv_rb), 32'h5bcd_ef01);

    wait_slot(10);
    send_l = 24'h654321;
    wait_slot(40);
    chk("midword_old", 32'(recv_l), 32'h123456);
    wait_slot(10);
    wait_slot(40);
    chk("midword_new", 32'(recv_l), 32'h654321);

    loop_a = 1'b0;
    repeat (3 * FR) @(negedge clk);

    k = 0;
    while ((m_n < 17000 || !meas_done) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("meas_done", 32'(meas_done), 32'd1);
    chk("def_loop_l", 32'(recv_ld), 32'h123456);
    chk("def_loop_r", 32'(recv_rd), 32'habcdef);

    loop_a = 1'b1;
    wait_slot(40);
    #3 arstn = 1'b0;
    #1;
    chk("mid_rst_sck", 32'(sck_a), 32'd0);
    chk("mid_rst_ws", 32'(ws_a), 32'd0);
    chk("mid_rst_sdo", 32'(sdo_a), 32'd0);
    chk("mid_rst_l", 32'(recv_l), 32'd0);
    chk("mid_rst_r", 32'(recv_r), 32'd0);
    chk("mid_rst_rb", 32'(recv_rb), 32'd0);
    repeat (3) @(negedge clk);
    arstn = 1'b1;

    repeat (2 * FR + 16) @(negedge clk);
    chk("post_rst_l", 32'(recv_l), 32'h654321);
    chk("post_rst_r", 32'(recv_r), 32'habcdef);
    chk("post_dw31_l", 32'(recv_lb), 32'h1234_5678);
    chk("post_dw31_r", 32'(recv_rb), 32'h5bcd_ef01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
